aes_key_sched_ctrl: RTL and testbench
=====================================

# aes_key_sched_ctrl

- Sequential AES-128 key-schedule controller.
- On a `start` pulse it expands a 128-bit cipher key into the 11 round keys (rounds 0..10), producing one round key per clock.
- Round constants are generated internally by doubling in GF(2^8).
- SubWord is done by an external shared S-box word unit through a combinational request/return port pair.
- Sits between the key input register and the cipher round datapath, which consumes round keys as they stream out or reads them back later from the optional store.

## Interface
Parameters:
- `ROUNDS`, 10, number of expansion rounds (AES-128)
- `WORD_SIZE`, 32, key-schedule word width
- `KEY_SIZE`, 128, cipher/round key width

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin expansion; sampled only in IDLE
- `key_in`  in  KEY_SIZE  cipher key, sampled the cycle `start` is accepted
- `sub_word_o`  out  WORD_SIZE  RotWord of working word 3, sent to the external S-box unit
- `sub_word_i`  in  WORD_SIZE  S-box(`sub_word_o`), returned combinationally in the same cycle
- `busy`  out  1  expansion in progress
- `rk_valid`  out  1  `rk_out` holds a valid round key this cycle
- `rk_round`  out  4  round index of `rk_out` (0..10)
- `rk_out`  out  KEY_SIZE  round key, {w0,w1,w2,w3}, w0 in the MSBs
- `done`  out  1  one-cycle pulse coincident with round 10
- `rd_idx`  in  4  store read index (KEY_STORE_EN only)
- `rd_key`  out  KEY_SIZE  stored round key (KEY_STORE_EN only)

## Operation
- States:
  - IDLE: `busy`=0.
    - `start`=1 → EXPAND: load `key_in` into the working register, set round counter to 0 and rcon to 0x01.
  - EXPAND: `busy`=1, `rk_valid`=1, `rk_out` = working register, `rk_round` = counter.
    - If counter < 10: the working register updates to the next round key and the counter increments.
    - If counter = 10: assert `done` → IDLE.
- Next key, with `t` = S-box(RotWord(w3)) taken from `sub_word_i`:
  - w0' = w0 ^ t ^ {rcon,24'h0}
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
- RotWord(w3) = {w3[23:0], w3[31:24]}.
- `sub_word_o` is driven in every state; it does not depend on `sub_word_i`, so no combinational loop.
- rcon update: xtime per round (rcon<<1, XOR 0x1B if bit 7 was set), giving the sequence 01,02,04,08,10,20,40,80,1B,36.
- `start` while `busy`=1 is ignored and the expansion in progress is not disturbed.
- `start` in the cycle `done` is asserted is ignored; a new start is accepted only from IDLE.
- All XOR arithmetic is width-exact; no truncation or extension.

## Timing
- `start` accepted at cycle T → round r appears at T+1+r with `rk_valid`=1; round 0 is `key_in` unchanged.
- `done`=1 at T+11, together with round 10; `busy`=0 from T+12.
- Throughput: a new expansion can start at the earliest at T+12, giving a 12-cycle period.
- Reset values, applied immediately while `rst`=1 regardless of state:
  - `busy`=0, `rk_valid`=0, `done`=0, `rk_round`=0, `rk_out`=0.
  - rcon register = 0x01, state = IDLE.
  - Store cleared to 0.
- Reset mid-expansion aborts it; no further `rk_valid` pulses occur until a new `start`.
- Outputs are registered except `sub_word_o` and `rd_key`.

## Configuration
Macro: `AES_KEY_SCHED_KEY_STORE_EN`.
- **Defined:**
  - An 11×KEY_SIZE register store captures `rk_out` at `rk_round` on every `rk_valid` cycle.
  - `rd_key` = store[`rd_idx`] combinationally; `rd_idx` > 10 returns 0.
  - A write and a read of the same index in the same cycle return the old contents.
  - The store is not cleared by `start`; it retains the last complete or partial expansion.
- **Undefined:** no store; the `rd_idx`/`rd_key` ports are absent, and keys are available only as the `rk_valid` stream.

## Test plan
The bench supplies a combinational S-box model on `sub_word_i` in every scenario.
- **FIPS-197 key.** Stimulus: `key_in`=2b7e151628aed2a6abf7158809cf4f3c, `start` pulse.
  - Round 0 = `key_in` at T+1.
  - Round 1 = a0fafe1788542cb123a339392a6c7605 at T+2.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at T+11, with `done`=1.
- **Rcon wrap.** Monitor the rcon value used per round → 01..80, then 1B at round 9 and 36 at round 10.
- **Start while busy.** Second `start` with a different key at T+5 → the stream is unchanged, round 10 still d014…0ca6, `busy` falls at T+12.
- **Back-to-back.** `start` held high continuously → a new expansion begins at T+12, round 0 at T+13, and no `rk_valid` at T+12.
- **Reset mid-operation.** `rst` asserted at T+6 → all outputs 0 immediately. After release, `start` with the all-zero key gives round 1 = 62636363626363636263636362636363.
- **Store (macro defined).** After the FIPS expansion: `rd_idx`=10 → d014…0ca6, `rd_idx`=0 → `key_in`, `rd_idx`=15 → 0.

Source files
------------

// File: rtl/aes_key_sched_ctrl_if.sv
// rtl/aes_key_sched_ctrl_if.sv - key-schedule controller handshake, S-box and round-key stream bundle
interface aes_key_sched_ctrl_if #(
  parameter int WORD_SIZE = 32,
  parameter int KEY_SIZE  = 128
);
  logic                 start;
  logic [KEY_SIZE-1:0]  key_in;
  logic [WORD_SIZE-1:0] sub_word_o;
  logic [WORD_SIZE-1:0] sub_word_i;
  logic                 busy;
  logic                 rk_valid;
  logic [3:0]           rk_round;
  logic [KEY_SIZE-1:0]  rk_out;
  logic                 done;

  // Key source / round datapath / S-box owner side
  modport master (
    output start, key_in, sub_word_i,
    input  sub_word_o, busy, rk_valid, rk_round, rk_out, done
  );

  // Key-schedule controller side
  modport slave (
    input  start, key_in, sub_word_i,
    output sub_word_o, busy, rk_valid, rk_round, rk_out, done
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - sequential AES-128 key expansion, one round key per clock; optional store via AES_KEY_SCHED_KEY_STORE_EN
module aes_key_sched_ctrl #(
  parameter int ROUNDS    = 10,
  parameter int WORD_SIZE = 32,
  parameter int KEY_SIZE  = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_key_sched_ctrl_if.slave  bus
`ifdef AES_KEY_SCHED_KEY_STORE_EN
  ,
  input  logic [3:0]           rd_idx,
  output logic [KEY_SIZE-1:0]  rd_key
`endif
);

  typedef enum logic {IDLE, EXPAND} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

  state_t               state_q, state_d;
  logic [KEY_SIZE-1:0]  work_q, work_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [7:0]           rcon_q, rcon_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;

  logic [WORD_SIZE-1:0] w0, w1, w2, w3;
  logic [WORD_SIZE-1:0] n0, n1, n2, n3;
  logic [KEY_SIZE-1:0]  next_key;
  logic [7:0]           rcon_next;

  // The working register doubles as the presented round key
  assign w0 = work_q[KEY_SIZE-1 -: WORD_SIZE];
  assign w1 = work_q[KEY_SIZE-1-WORD_SIZE -: WORD_SIZE];
  assign w2 = work_q[2*WORD_SIZE-1 -: WORD_SIZE];
  assign w3 = work_q[WORD_SIZE-1:0];

  // RotWord of w3 goes to the shared S-box; depends only on flops, so no loop through sub_word_i
  assign bus.sub_word_o = {w3[WORD_SIZE-9:0], w3[WORD_SIZE-1 -: 8]};

  // Next round key from the S-box result and the current round constant
  always_comb begin
    n0       = w0 ^ bus.sub_word_i ^ {rcon_q, {(WORD_SIZE-8){1'b0}}};
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
    rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    rcon_d  = rcon_q;
    busy_d  = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = EXPAND;
          work_d  = bus.key_in;
          cnt_d   = 4'd0;
          rcon_d  = 8'h01;
          busy_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
      EXPAND: begin
        // start is deliberately ignored here, including the done cycle
        if (cnt_q < LAST_ROUND) begin
          work_d  = next_key;
          cnt_d   = cnt_q + 4'd1;
          rcon_d  = rcon_next;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          done_d  = (cnt_q == LAST_ROUND - 4'd1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state and outputs; reset aborts any expansion immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= 4'd0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rk_valid = valid_q;
  assign bus.rk_round = cnt_q;
  assign bus.rk_out   = work_q;
  assign bus.done     = done_q;

`ifdef AES_KEY_SCHED_KEY_STORE_EN
  logic [KEY_SIZE-1:0] store_q [0:ROUNDS];
  logic [KEY_SIZE-1:0] store_d [0:ROUNDS];

  // Capture each streamed round key at its round index; start does not clear it
  always_comb begin
    store_d = store_q;
    if (valid_q && (cnt_q <= LAST_ROUND)) begin
      store_d[cnt_q] = work_q;
    end
  end

  // Store registers; reads see the pre-write contents within a cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= ROUNDS; i++) begin
        store_q[i] <= '0;
      end
    end else begin
      store_q <= store_d;
    end
  end

  assign rd_key = (rd_idx <= LAST_ROUND) ? store_q[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - randomized self-checking bench with FIPS-197 reference key schedule
module tb_aes_key_sched_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  aes_key_sched_ctrl_if #(.WORD_SIZE(32), .KEY_SIZE(128)) bus ();

`ifdef AES_KEY_SCHED_KEY_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic [127:0] store_model [0:10];
`endif

  aes_key_sched_ctrl #(.ROUNDS(10), .WORD_SIZE(32), .KEY_SIZE(128)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus)
`ifdef AES_KEY_SCHED_KEY_STORE_EN
    ,
    .rd_idx (rd_idx),
    .rd_key (rd_key)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox   [0:255];
  logic [127:0] rk_exp [0:10];
  logic [127:0] got    [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

  // Combinational S-box word unit
  assign bus.sub_word_i = {sbox[bus.sub_word_o[31:24]], sbox[bus.sub_word_o[23:16]],
                           sbox[bus.sub_word_o[15:8]],  sbox[bus.sub_word_o[7:0]]};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction

  // FIPS-197 word-indexed expansion w[0..43]
  task automatic build_model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc [0:9];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc[i/4-1], 24'h0};
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk_exp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_round(input int r, input logic [127:0] exp);
    chk($sformatf("valid_r%0d", r), 128'(bus.rk_valid), 128'd1);
    chk($sformatf("round_r%0d", r), 128'(bus.rk_round), 128'(r));
    chk($sformatf("key_r%0d", r), bus.rk_out, exp);
    chk($sformatf("done_r%0d", r), 128'(bus.done), 128'(r == 10));
    chk($sformatf("busy_r%0d", r), 128'(bus.busy), 128'd1);
    got[r] = bus.rk_out;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 128'(bus.busy), 128'd0);
    chk({tag, "_valid"}, 128'(bus.rk_valid), 128'd0);
    chk({tag, "_done"}, 128'(bus.done), 128'd0);
  endtask

  // One full expansion from IDLE, checked every cycle against the model
  task automatic run_full(input logic [127:0] k, input string tag);
    build_model(k);
    bus.key_in = k;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int r = 0; r <= 10; r++) begin
`ifdef AES_KEY_SCHED_KEY_STORE_EN
      rd_idx = 4'(r);
      #1;
      chk($sformatf("%s_store_old_r%0d", tag, r), rd_key, store_model[r]);
`endif
      chk_round(r, rk_exp[r]);
      if (r < 10) tick();
    end
    tick();
    chk_idle({tag, "_end"});
`ifdef AES_KEY_SCHED_KEY_STORE_EN
    for (int r = 0; r <= 10; r++) store_model[r] = rk_exp[r];
`endif
  endtask

  initial begin
    logic [127:0] k1, k2;
    logic [127:0] exp1 [0:10];
    logic [7:0]   inv;

    bus.start  = 1'b0;
    bus.key_in = '0;
`ifdef AES_KEY_SCHED_KEY_STORE_EN
    rd_idx = 4'd0;
    for (int r = 0; r <= 10; r++) store_model[r] = '0;
`endif
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = affine(inv);
    end

    // Reset state
    tick();
    tick();
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_valid", 128'(bus.rk_valid), 128'd0);
    chk("rst_done", 128'(bus.done), 128'd0);
    chk("rst_round", 128'(bus.rk_round), 128'd0);
    chk("rst_key", bus.rk_out, 128'd0);
    rst = 1'b0;
    tick();
    chk_idle("post_rst");

    // FIPS-197 key
    run_full(FIPS_KEY, "fips");
    chk("fips_r0", got[0], FIPS_KEY);
    chk("fips_r1", got[1], FIPS_R1);
    chk("fips_r10", got[10], FIPS_R10);

`ifdef AES_KEY_SCHED_KEY_STORE_EN
    rd_idx = 4'd10; #1; chk("store_idx10", rd_key, FIPS_R10);
    rd_idx = 4'd0;  #1; chk("store_idx0", rd_key, FIPS_KEY);
    rd_idx = 4'd15; #1; chk("store_idx15", rd_key, 128'd0);
`endif

    // Randomized keys
    for (int n = 0; n < 4; n++) begin
      run_full({$urandom, $urandom, $urandom, $urandom}, $sformatf("rand%0d", n));
    end

    // Start while busy: second start at T+5 must not disturb the stream
    build_model(FIPS_KEY);
    bus.key_in = FIPS_KEY;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int r = 0; r <= 10; r++) begin
      chk_round(r, rk_exp[r]);
      if (r == 4) begin
        bus.start  = 1'b1;
        bus.key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      if (r == 5) bus.start = 1'b0;
      if (r < 10) tick();
    end
    chk("busy_start_r10", got[10], FIPS_R10);
    tick();
    chk_idle("busy_start_t12");
`ifdef AES_KEY_SCHED_KEY_STORE_EN
    for (int r = 0; r <= 10; r++) store_model[r] = rk_exp[r];
`endif

    // Back-to-back: start held high
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    build_model(k1);
    for (int r = 0; r <= 10; r++) exp1[r] = rk_exp[r];
    build_model(k2);
    bus.key_in = k1;
    bus.start  = 1'b1;
    tick();
    bus.key_in = k2;
    for (int r = 0; r <= 10; r++) begin
      chk_round(r, exp1[r]);
      if (r < 10) tick();
    end
    tick();
    chk_idle("b2b_t12");
    tick();
    bus.start = 1'b0;
    for (int r = 0; r <= 10; r++) begin
      chk_round(r, rk_exp[r]);
      if (r < 10) tick();
    end
    tick();
    chk_idle("b2b_end");
`ifdef AES_KEY_SCHED_KEY_STORE_EN
    for (int r = 0; r <= 10; r++) store_model[r] = rk_exp[r];
`endif

    // Reset mid-operation at T+6
    build_model({$urandom, $urandom, $urandom, $urandom});
    bus.key_in = rk_exp[0];
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int r = 0; r <= 5; r++) begin
      chk_round(r, rk_exp[r]);
      if (r < 5) tick();
    end
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 128'(bus.busy), 128'd0);
    chk("midrst_valid", 128'(bus.rk_valid), 128'd0);
    chk("midrst_done", 128'(bus.done), 128'd0);
    chk("midrst_round", 128'(bus.rk_round), 128'd0);
    chk("midrst_key", bus.rk_out, 128'd0);
`ifdef AES_KEY_SCHED_KEY_STORE_EN
    rd_idx = 4'd0; #1; chk("midrst_store", rd_key, 128'd0);
    for (int r = 0; r <= 10; r++) store_model[r] = '0;
`endif
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_idle($sformatf("after_rst_c%0d", c));
    end
    run_full(128'd0, "zero");
    chk("zero_r1", got[1], ZERO_R1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
